fetch_decode_unit: RTL and testbench
====================================

// Module: fetch_decode_unit
// PURPOSE
//  Program counter, instruction register and instruction decoder for the K&S core.
//  Sits in the datapath directly upstream of control_unit.
//  Captures memory read data into IR, advances or branches the PC, and muxes the memory address.
//  Presents decoded_instruction plus register/address fields for control_unit and the register file.
// PARAMETERS
//  ADDR_W  5   memory word-address width; PC, IR address field and ram_addr width
//  DATA_W  16  instruction/data word width; opcode = IR[15:8]
// PORTS
//  clk                  in   1       core clock; all state updates on rising edge
//  rst_n                in   1       reset, asynchronous, active-low
//  ir_enable            in   1       load IR from data_in at next edge
//  pc_enable            in   1       update PC at next edge
//  branch               in   1       with pc_enable: PC <= IR mem_addr field, else PC+1
//  addr_sel             in   1       1: ram_addr = PC, 0: ram_addr = IR mem_addr field
//  data_in              in   DATA_W  memory read data
//  ram_addr             out  ADDR_W  memory address
//  decoded_instruction  out  enum    decoded_instruction_type from k_and_s_pkg
//  a_addr/b_addr/c_addr out  2 each  register-file source A, source B, destination
//  illegal_op           out  1       IR holds an unassigned opcode
// BEHAVIOUR
//  Reset, async on rst_n low: PC=0, IR=16'h0000 (NOP)
//   -> decoded_instruction=I_NOP, illegal_op=0, a/b/c_addr=0, ram_addr=0 when addr_sel=1.
//  IR: on edge with ir_enable=1, IR <= data_in; otherwise IR holds.
//  PC, on edge with pc_enable=1:
//   - branch=1 -> PC <= IR[ADDR_W-1:0], using the IR value before the edge
//   - branch=0 -> PC <= PC+1, modulo 2**ADDR_W, so 31 -> 0 with no flag
//   - branch is ignored when pc_enable=0.
//  ir_enable and pc_enable in the same cycle: both update. The PC branch target comes from the old IR.
//  Outputs are combinational from the registered IR/PC:
//   - decoded_instruction valid the cycle after an ir_enable edge; no further latency
//   - ram_addr follows addr_sel combinationally, zero latency.
//  Opcode map (IR[15:8]) -> decoded value:
//   00 NOP        01 BRANCH   02 BZERO   03 BNEG   04 BOV   05 BNZERO   06 BNNEG   07 BNOV
//   81 LOAD       82 STORE    91 MOVE    A1 ADD    A2 SUB   A3 AND      A4 OR      FF HALT
//  Any other opcode: I_NOP with illegal_op=1 while that IR value is held.
//  Fields (zero for instructions that do not use them):
//   - LOAD/STORE: register [6:5] -> c_addr (LOAD dest) / a_addr (STORE src); address [4:0]
//   - MOVE: c_addr=[3:2], a_addr=[1:0]
//   - ALU ops: c_addr=[5:4], a_addr=[3:2], b_addr=[1:0]
//   - branches: target [4:0]; NOP/HALT: all register fields 0.
//  rst_n asserted mid-operation: all state clears immediately, independent of clk.
//   Release is synchronised upstream.
// STRUCTURE
//  k_and_s_pkg holds: decoded_instruction_type enum, opcode constants, field bit-position localparams.
//  Sub-module instruction_decoder: purely combinational IR -> decoded_instruction/fields/illegal_op.
//  This module holds PC, IR and the address mux.
// TESTING
//  1. rst_n low mid-run with PC=9 -> PC=0, IR=0, I_NOP, ram_addr=0 (addr_sel=1) without a clock.
//  2. data_in=16'hA1_1B, ir_enable pulse -> next cycle I_ADD, c=1, a=2, b=3, illegal_op=0.
//  3. PC=31, pc_enable=1, branch=0 -> PC=0; pc_enable=0, branch=1 -> PC holds.
//  4. IR=16'h0214, pc_enable=1, branch=1 -> PC=20.
//     In the same cycle, ir_enable with data_in=16'h0103 -> PC=20, then IR=0103.
//  5. IR=16'h8113, addr_sel=0 -> ram_addr=19, I_LOAD, c_addr=0; addr_sel=1 -> ram_addr=PC.
//  6. data_in=16'h5500 loaded -> I_NOP, illegal_op=1; next load 16'hFF00 -> I_HALT, illegal_op=0.

Source files
------------

// File: rtl/k_and_s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : k_and_s_pkg
// Brief    : Shared types and constants for the K&S core fetch/decode path.
// Revision : 1.0
// ============================================================================
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNZERO, I_BNNEG, I_BNOV,
    I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
  } decoded_instruction_type;

  localparam int c_opcode_w = 8;

  localparam logic [7:0] c_op_nop    = 8'h00;
  localparam logic [7:0] c_op_branch = 8'h01;
  localparam logic [7:0] c_op_bzero  = 8'h02;
  localparam logic [7:0] c_op_bneg   = 8'h03;
  localparam logic [7:0] c_op_bov    = 8'h04;
  localparam logic [7:0] c_op_bnzero = 8'h05;
  localparam logic [7:0] c_op_bnneg  = 8'h06;
  localparam logic [7:0] c_op_bnov   = 8'h07;
  localparam logic [7:0] c_op_load   = 8'h81;
  localparam logic [7:0] c_op_store  = 8'h82;
  localparam logic [7:0] c_op_move   = 8'h91;
  localparam logic [7:0] c_op_add    = 8'hA1;
  localparam logic [7:0] c_op_sub    = 8'hA2;
  localparam logic [7:0] c_op_and    = 8'hA3;
  localparam logic [7:0] c_op_or     = 8'hA4;
  localparam logic [7:0] c_op_halt   = 8'hFF;

  // LSB positions of the 2-bit register fields inside the IR operand byte
  localparam int c_ls_reg_lsb = 5;
  localparam int c_mov_c_lsb  = 2;
  localparam int c_mov_a_lsb  = 0;
  localparam int c_alu_c_lsb  = 4;
  localparam int c_alu_a_lsb  = 2;
  localparam int c_alu_b_lsb  = 0;

endpackage
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decoder
// Brief    : Combinational IR -> decoded instruction, register fields, illegal flag.
// Revision : 1.0
// ============================================================================
module instruction_decoder
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]      ir,
  output decoded_instruction_type decoded_instruction,
  output logic [1:0]             a_addr,
  output logic [1:0]             b_addr,
  output logic [1:0]             c_addr,
  output logic                   illegal_op
);

  logic [c_opcode_w-1:0] w_opcode;
  logic                  w_unused_ir7;

  assign w_opcode     = ir[DATA_W-1 -: c_opcode_w];
  assign w_unused_ir7 = ir[7];

  always_comb begin
    decoded_instruction = I_NOP;
    a_addr              = 2'd0;
    b_addr              = 2'd0;
    c_addr              = 2'd0;
    illegal_op          = 1'b0;
    case (w_opcode)
      c_op_nop:    decoded_instruction = I_NOP;
      c_op_branch: decoded_instruction = I_BRANCH;
      c_op_bzero:  decoded_instruction = I_BZERO;
      c_op_bneg:   decoded_instruction = I_BNEG;
      c_op_bov:    decoded_instruction = I_BOV;
      c_op_bnzero: decoded_instruction = I_BNZERO;
      c_op_bnneg:  decoded_instruction = I_BNNEG;
      c_op_bnov:   decoded_instruction = I_BNOV;
      c_op_halt:   decoded_instruction = I_HALT;
      c_op_load: begin
        decoded_instruction = I_LOAD;
        c_addr              = ir[c_ls_reg_lsb +: 2];
      end
      c_op_store: begin
        decoded_instruction = I_STORE;
        a_addr              = ir[c_ls_reg_lsb +: 2];
      end
      c_op_move: begin
        decoded_instruction = I_MOVE;
        c_addr              = ir[c_mov_c_lsb +: 2];
        a_addr              = ir[c_mov_a_lsb +: 2];
      end
      c_op_add, c_op_sub, c_op_and, c_op_or: begin
        unique case (w_opcode)
          c_op_add: decoded_instruction = I_ADD;
          c_op_sub: decoded_instruction = I_SUB;
          c_op_and: decoded_instruction = I_AND;
          default:  decoded_instruction = I_OR;
        endcase
        c_addr = ir[c_alu_c_lsb +: 2];
        a_addr = ir[c_alu_a_lsb +: 2];
        b_addr = ir[c_alu_b_lsb +: 2];
      end
      default: illegal_op = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_unit
// Brief    : PC, IR and memory address mux feeding the instruction decoder.
// Revision : 1.0
// ============================================================================
module fetch_decode_unit
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ir_enable,
  input  logic                    pc_enable,
  input  logic                    branch,
  input  logic                    addr_sel,
  input  logic [DATA_W-1:0]       data_in,
  output logic [ADDR_W-1:0]       ram_addr,
  output decoded_instruction_type decoded_instruction,
  output logic [1:0]              a_addr,
  output logic [1:0]              b_addr,
  output logic [1:0]              c_addr,
  output logic                    illegal_op
);

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] w_pc_next;

  // Branch target is taken from the IR as it stands before this edge
  assign w_pc_next = branch ? r_ir[ADDR_W-1:0] : r_pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if (pc_enable) r_pc <= w_pc_next;
      if (ir_enable) r_ir <= data_in;
    end
  end

  assign ram_addr = addr_sel ? r_pc : r_ir[ADDR_W-1:0];

  instruction_decoder #(
    .DATA_W (DATA_W)
  ) u_decoder (
    .ir                  (r_ir),
    .decoded_instruction (decoded_instruction),
    .a_addr              (a_addr),
    .b_addr              (b_addr),
    .c_addr              (c_addr),
    .illegal_op          (illegal_op)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_unit
// Brief    : Directed and randomized self-checking bench for fetch_decode_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_decode_unit;
  import k_and_s_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    ir_enable = 1'b0;
  logic                    pc_enable = 1'b0;
  logic                    branch = 1'b0;
  logic                    addr_sel = 1'b1;
  logic [15:0]             data_in = '0;
  logic [4:0]              ram_addr;
  decoded_instruction_type decoded_instruction;
  logic [1:0]              a_addr, b_addr, c_addr;
  logic                    illegal_op;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  int m_pc = 0;
  int m_ir = 0;

  typedef struct {
    decoded_instruction_type ins;
    int a, b, c;
    bit ill;
  } dec_t;

  fetch_decode_unit #(.ADDR_W(5), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ir_enable(ir_enable), .pc_enable(pc_enable),
    .branch(branch), .addr_sel(addr_sel), .data_in(data_in), .ram_addr(ram_addr),
    .decoded_instruction(decoded_instruction), .a_addr(a_addr), .b_addr(b_addr),
    .c_addr(c_addr), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic dec_t ref_decode(int ir);
    dec_t d;
    int op  = (ir >> 8) & 255;
    int lo  = ir & 255;
    d.ins = I_NOP; d.a = 0; d.b = 0; d.c = 0; d.ill = 1'b0;
    case (op)
      'h00: d.ins = I_NOP;
      'h01: d.ins = I_BRANCH;
      'h02: d.ins = I_BZERO;
      'h03: d.ins = I_BNEG;
      'h04: d.ins = I_BOV;
      'h05: d.ins = I_BNZERO;
      'h06: d.ins = I_BNNEG;
      'h07: d.ins = I_BNOV;
      'hFF: d.ins = I_HALT;
      'h81: begin d.ins = I_LOAD;  d.c = (lo / 32) % 4; end
      'h82: begin d.ins = I_STORE; d.a = (lo / 32) % 4; end
      'h91: begin d.ins = I_MOVE;  d.c = (lo / 4) % 4; d.a = lo % 4; end
      'hA1, 'hA2, 'hA3, 'hA4: begin
        d.ins = (op == 'hA1) ? I_ADD : (op == 'hA2) ? I_SUB : (op == 'hA3) ? I_AND : I_OR;
        d.c = (lo / 16) % 4; d.a = (lo / 4) % 4; d.b = lo % 4;
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the current addr_sel
  task automatic check_all(input string tag);
    dec_t d = ref_decode(m_ir);
    chk({tag, ":ram_addr"}, 32'(ram_addr), addr_sel ? m_pc : (m_ir % 32));
    chk({tag, ":instr"}, 32'(decoded_instruction), 32'(d.ins));
    chk({tag, ":a"}, 32'(a_addr), d.a);
    chk({tag, ":b"}, 32'(b_addr), d.b);
    chk({tag, ":c"}, 32'(c_addr), d.c);
    chk({tag, ":illegal"}, 32'(illegal_op), 32'(d.ill));
  endtask

  task automatic step(input bit ie, input bit pe, input bit br, input logic [15:0] din);
    @(negedge clk);
    ir_enable = ie; pc_enable = pe; branch = br; data_in = din;
    @(posedge clk);
    if (pe) m_pc = br ? (m_ir % 32) : (m_pc + 1) % 32;
    if (ie) m_ir = din;
    #1;
    ir_enable = 1'b0; pc_enable = 1'b0; branch = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    m_pc = 0; m_ir = 0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] valid_ops [16] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400,
    16'h0500, 16'h0600, 16'h0700, 16'h8100, 16'h8200, 16'h9100, 16'hA100,
    16'hA200, 16'hA300, 16'hA400, 16'hFF00};

  initial begin
    // Reset state
    #2;
    addr_sel = 1'b1;
    check_all("reset");
    release_reset();

    // Test 1: async reset mid-run with PC=9, no clock edge needed
    for (int i = 0; i < 9; i++) step(0, 1, 0, '0);
    step(1, 0, 0, 16'hA11B);
    check_all("pc9");
    async_reset();
    check_all("async_rst");
    addr_sel = 1'b0; #1;
    check_all("async_rst_as0");
    addr_sel = 1'b1;
    release_reset();

    // Test 2: ADD decode
    step(1, 0, 0, 16'hA11B);
    check_all("add");

    // Test 3: PC wrap and branch ignored without pc_enable
    for (int i = 0; i < 31; i++) step(0, 1, 0, '0);
    check_all("pc31");
    step(0, 1, 0, '0);
    check_all("pc_wrap");
    step(0, 0, 1, '0);
    check_all("br_no_pe");

    // Test 4: branch uses old IR while IR loads a new word
    step(1, 0, 0, 16'h0214);
    step(1, 1, 1, 16'h0103);
    check_all("br_old_ir");

    // Test 5: LOAD with direct address on the mux
    step(1, 0, 0, 16'h8113);
    addr_sel = 1'b0; #1;
    check_all("load_as0");
    addr_sel = 1'b1; #1;
    check_all("load_as1");

    // Test 6: illegal opcode then HALT
    step(1, 0, 0, 16'h5500);
    check_all("illegal");
    step(1, 0, 0, 16'hFF00);
    check_all("halt");

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] w;
      w = ($urandom_range(0, 3) == 0) ? 16'($urandom)
          : (valid_ops[$urandom_range(0, 15)] | 16'($urandom_range(0, 255)));
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), w);
      addr_sel = bit'($urandom_range(0, 1)); #1;
      check_all("rand");
      if (i == 200) begin
        async_reset();
        check_all("rand_rst");
        release_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
